// File: rtl/frac_lutk_cfg.sv
// rtl/frac_lutk_cfg.sv - fracturable K-input LUT with configuration-chain load tracking
// and an optional registered output; all logic runs on prog_clk.
module frac_lutk_cfg #(
  parameter int K          = 4,
  parameter bit REG_OUT_EN = 1'b1
) (
  input  logic         prog_clk,
  input  logic         pReset,
  input  logic         ccff_en,
  input  logic         ccff_head,
  input  logic [K-1:0] frac_logic_in,
  input  logic         ff_en,
  output logic [1:0]   frac_logic_out,
  output logic         ccff_tail,
  output logic         cfg_done,
  output logic         cfg_overrun
);

  localparam int TT_LEN  = 2**K;
  localparam int CFG_LEN = TT_LEN + 2;
  localparam int CNT_W   = $clog2(CFG_LEN + 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    DONE = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_cnt_nxt;
  logic [CFG_LEN-1:0] cfg;

  logic [TT_LEN-1:0]  truth_table;
  logic               mode_frac;
  logic               reg_sel;
  logic [K-2:0]       addr_lo;
  logic               lut_lo;
  logic               lut_hi;
  logic               lutk;
  logic               o0;
  logic               out0_sel;

  // Shift chain: new bit enters at cfg[0]; the oldest bit leaves from cfg[CFG_LEN-1].
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      cfg <= '0;
    end else if (ccff_en) begin
      cfg <= {cfg[CFG_LEN-2:0], ccff_head};
    end
  end

  assign ccff_tail = cfg[CFG_LEN-1];

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state   <= LOAD;
      bit_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    case (state)
      LOAD: begin
        if (ccff_en) begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(CFG_LEN - 1)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (ccff_en) begin
          state_nxt = ERR;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  assign cfg_done    = (state == DONE);
  assign cfg_overrun = (state == ERR);

  // The upper input picks between the two (K-1)-input halves of the table.
  assign truth_table = cfg[TT_LEN-1:0];
  assign mode_frac   = cfg[TT_LEN];
  assign reg_sel     = cfg[TT_LEN+1];
  assign addr_lo     = frac_logic_in[K-2:0];
  assign lut_lo      = truth_table[{1'b0, addr_lo}];
  assign lut_hi      = truth_table[{1'b1, addr_lo}];
  assign lutk        = frac_logic_in[K-1] ? lut_hi : lut_lo;
  assign o0          = mode_frac ? lut_lo : lutk;

  generate
    if (REG_OUT_EN) begin : g_out_ff
      logic out_ff;

      // Captures only in user mode; a shift arriving in DONE wins over ff_en.
      always_ff @(posedge prog_clk) begin
        if (pReset) begin
          out_ff <= 1'b0;
        end else if (ff_en && (state == DONE) && !ccff_en) begin
          out_ff <= o0;
        end
      end

      assign out0_sel = reg_sel ? out_ff : o0;
    end else begin : g_no_out_ff
      assign out0_sel = o0;
    end
  endgenerate

  assign frac_logic_out = cfg_done ? {lut_hi, out0_sel} : 2'b00;

endmodule

// File: tb/tb_frac_lutk_cfg.sv
// tb/tb_frac_lutk_cfg.sv - scoreboard bench for frac_lutk_cfg (K=4, registered output present)
module tb_frac_lutk_cfg;

  logic       prog_clk = 1'b0;
  logic       pReset = 1'b1;
  logic       ccff_en = 1'b0;
  logic       ccff_head = 1'b0;
  logic       ff_en = 1'b0;
  logic [3:0] frac_logic_in = 4'h0;
  logic [1:0] frac_logic_out;
  logic       ccff_tail;
  logic       cfg_done;
  logic       cfg_overrun;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] exp;
    logic [4:0] mask;
    string      name;
  } exp_t;

  exp_t q[$];

  // Observed vector layout: {out[1], out[0], cfg_done, cfg_overrun, ccff_tail}
  localparam logic [4:0] M_ALL  = 5'b11111;
  localparam logic [4:0] M_NOTL = 5'b11110;
  localparam logic [4:0] M_OD   = 5'b11100;

  frac_lutk_cfg #(.K(4), .REG_OUT_EN(1'b1)) dut (
    .prog_clk       (prog_clk),
    .pReset         (pReset),
    .ccff_en        (ccff_en),
    .ccff_head      (ccff_head),
    .frac_logic_in  (frac_logic_in),
    .ff_en          (ff_en),
    .frac_logic_out (frac_logic_out),
    .ccff_tail      (ccff_tail),
    .cfg_done       (cfg_done),
    .cfg_overrun    (cfg_overrun)
  );

  always #5 prog_clk = ~prog_clk;

  initial begin : monitor
    exp_t e;
    logic [4:0] act;
    forever begin
      @(negedge prog_clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {frac_logic_out, cfg_done, cfg_overrun, ccff_tail};
        checks++;
        if ((act & e.mask) !== (e.exp & e.mask)) begin
          failures++;
          $display("FAIL %s: actual=%b required=%b mask=%b", e.name, act, e.exp, e.mask);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic expect_now(input string name, input logic [4:0] exp, input logic [4:0] mask);
    q.push_back('{exp: exp, mask: mask, name: name});
    @(negedge prog_clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic head, input logic fe);
    ccff_en   = en;
    ccff_head = head;
    ff_en     = fe;
    @(posedge prog_clk);
    #1;
    ccff_en   = 1'b0;
    ff_en     = 1'b0;
  endtask

  task automatic load_n(input logic [17:0] v, input int n);
    for (int i = 17; i > 17 - n; i--) drive(1'b1, v[i], 1'b0);
  endtask

  task automatic do_reset();
    pReset    = 1'b1;
    ccff_en   = 1'b1;
    ccff_head = 1'b1;
    ff_en     = 1'b1;
    @(posedge prog_clk);
    #1;
    pReset    = 1'b0;
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
    ff_en     = 1'b0;
  endtask

  logic [17:0] va, vb, vc, vd, ve;

  initial begin : stimulus
    va = {1'b0, 1'b0, 16'h8000};
    vb = {1'b0, 1'b1, 16'hFF00};
    vc = {1'b0, 1'b1, 16'h00F0};
    vd = {1'b1, 1'b0, 16'hFFFF};
    ve = {1'b0, 1'b0, 16'hFFFF};

    @(negedge prog_clk);
    do_reset();
    expect_now("reset", 5'b00000, M_ALL);
    for (int i = 0; i < 10; i++) begin
      frac_logic_in = 4'(i + 5);
      drive(1'b0, 1'b1, 1'b1);
      expect_now("idle_load", 5'b00000, M_ALL);
    end

    // Single-minterm table, plain K-LUT mode
    load_n(va, 17);
    expect_now("a_17_shifts", 5'b00000, M_NOTL);
    drive(1'b1, va[0], 1'b0);
    frac_logic_in = 4'hF;
    expect_now("a_in_f", 5'b11100, M_ALL);
    frac_logic_in = 4'h7;
    expect_now("a_in_7", 5'b10100, M_ALL);
    frac_logic_in = 4'h0;
    expect_now("a_in_0", 5'b00100, M_ALL);

    // Fractured mode: out[0] follows the lower half only
    do_reset();
    load_n(vb, 18);
    frac_logic_in = 4'h0;
    expect_now("b_in_0", 5'b10100, M_ALL);
    frac_logic_in = 4'h8;
    expect_now("b_in_8", 5'b10100, M_ALL);
    frac_logic_in = 4'hF;
    expect_now("b_in_f", 5'b10100, M_ALL);

    do_reset();
    load_n(vc, 18);
    frac_logic_in = 4'h4;
    expect_now("c_in_4", 5'b01100, M_ALL);
    frac_logic_in = 4'hC;
    expect_now("c_in_c", 5'b01100, M_ALL);

    // Registered output selected
    do_reset();
    load_n(vd, 17);
    expect_now("d_17_shifts", 5'b00000, M_ALL);
    drive(1'b1, vd[0], 1'b0);
    frac_logic_in = 4'h5;
    expect_now("d_ff_empty", 5'b10101, M_ALL);
    drive(1'b0, 1'b0, 1'b1);
    expect_now("d_ff_loaded", 5'b11101, M_ALL);
    drive(1'b0, 1'b0, 1'b0);
    expect_now("d_ff_hold", 5'b11101, M_ALL);

    // Overrun: 19th shift with ff_en also high
    drive(1'b1, 1'b0, 1'b1);
    expect_now("ovr_first", 5'b00010, M_ALL);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      expect_now("ovr_shift", 5'b00010, M_NOTL);
    end
    drive(1'b0, 1'b0, 1'b1);
    expect_now("ovr_idle", 5'b00010, M_NOTL);

    do_reset();
    expect_now("reset_after_ovr", 5'b00000, M_ALL);

    // Abort a partial load; the count must restart
    load_n(ve, 9);
    do_reset();
    expect_now("reset_mid_load", 5'b00000, M_ALL);
    load_n(ve, 17);
    expect_now("e_17_shifts", 5'b00000, M_NOTL);
    drive(1'b1, ve[0], 1'b0);
    frac_logic_in = 4'h3;
    expect_now("e_done", 5'b11100, M_ALL);
    frac_logic_in = 4'hB;
    expect_now("e_in_b", 5'b11100, M_OD);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge prog_clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
